// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
// Leading-zero blanking (macro SEG_SCAN_LZB_EN) uses is_zero() from here.
package seg_pkg;

  typedef logic [1:0] digit_idx_t;
  typedef logic [6:0] pattern_t;

  localparam pattern_t   SEG_BLANK = 7'b1111111;
  localparam pattern_t   SEG_ZERO  = 7'b0000001;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  function automatic logic is_zero(input pattern_t p);
    return (p == SEG_ZERO);
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot timer: counts PRESCALE cycles per digit slot and steps the digit index.
// Flags the blanking window at the start of each slot and the frame boundary.
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       slot_blank,
  output digit_idx_t idx,
  output logic       frame_boundary
);

  localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [TW-1:0] tick_reg;
  digit_idx_t    idx_reg;
  logic          slot_end;

  assign slot_end = (tick_reg == TW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_reg <= '0;
      idx_reg  <= '0;
    end else if (slot_end) begin
      tick_reg <= '0;
      // Two-bit index wraps 3 -> 0 on its own.
      idx_reg  <= idx_reg + 2'd1;
    end else begin
      tick_reg <= tick_reg + 1'b1;
    end
  end

  assign slot_blank     = (tick_reg < TW'(BLANK_CYCLES));
  assign idx            = idx_reg;
  assign frame_boundary = slot_end && (idx_reg == 2'd3);

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit 7-segment scan driver with a one-deep pending frame buffer.
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] d0,
  input  logic [6:0] d1,
  input  logic [6:0] d2,
  input  logic [6:0] d3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_done
);

  logic       slot_blank;
  digit_idx_t idx;
  logic       frame_boundary;

  seg_slot_timer #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .slot_blank     (slot_blank),
    .idx            (idx),
    .frame_boundary (frame_boundary)
  );

  pattern_t   din [4];
  pattern_t   active_reg [4];
  pattern_t   pend_reg [4];
  logic       pend_full_reg;
  logic       capture;
  logic       commit;
  logic [3:0] lzb_mask;
  logic [3:0] an_reg, an_next;
  pattern_t   seg_reg, seg_next;
  logic       frame_done_reg;

  assign din[0] = d0;
  assign din[1] = d1;
  assign din[2] = d2;
  assign din[3] = d3;

  // Capture needs an empty buffer and commit a full one, so they never coincide.
  assign capture  = in_valid && !pend_full_reg;
  assign commit   = frame_boundary && pend_full_reg;
  assign in_ready = !pend_full_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full_reg <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        active_reg[i] <= SEG_BLANK;
        pend_reg[i]   <= SEG_BLANK;
      end
    end else if (commit) begin
      pend_full_reg <= 1'b0;
      for (int i = 0; i < 4; i++) active_reg[i] <= pend_reg[i];
    end else if (capture) begin
      pend_full_reg <= 1'b1;
      for (int i = 0; i < 4; i++) pend_reg[i] <= din[i];
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // lead_zero[i]: digit i and every digit to its left hold the zero glyph.
  logic [3:0] lead_zero;
  assign lead_zero[3] = is_zero(active_reg[3]);
  for (genvar gi = 0; gi < 3; gi++) begin : g_lzb
    assign lead_zero[gi] = is_zero(active_reg[gi]) && lead_zero[gi+1];
  end
  assign lzb_mask = {lead_zero[3:1], 1'b0};
`else
  assign lzb_mask = 4'b0000;
`endif

  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_BLANK;
    if (!slot_blank && !lzb_mask[idx]) begin
      an_next[idx] = 1'b0;
      seg_next     = active_reg[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg         <= AN_OFF;
      seg_reg        <= SEG_BLANK;
      frame_done_reg <= 1'b0;
    end else begin
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      frame_done_reg <= frame_boundary;
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with PRESCALE=8, BLANK_CYCLES=2.
// Expected outputs are queued at each clock edge and compared half a cycle later.
module tb_seg_scan_driver;

  localparam int P     = 8;
  localparam int B     = 2;
  localparam int FRAME = 4 * P;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [6:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic       in_ready;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_done;

  seg_scan_driver #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t       sb_q[$];
  int         m_pos;
  logic [6:0] m_act [4];
  logic [6:0] m_pend [4];
  bit         m_pf;
  bit         gap_chk = 1'b1;
  int         gap_run;
  logic [3:0] last_lit;
  int         lit3_zero_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_dark(input int i);
`ifdef SEG_SCAN_LZB_EN
    if (i == 0) return 1'b0;
    for (int j = i; j < 4; j++)
      if (m_act[j] != 7'b0000001) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_pos = 0;
    m_pf  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_act[i]  = 7'h7F;
      m_pend[i] = 7'h7F;
    end
    sb_q.delete();
    gap_run  = 0;
    last_lit = 4'hF;
  endtask

  // One clock: model advances on the rising edge, DUT is checked on the falling edge.
  task automatic step();
    exp_t e;
    exp_t got_e;
    int   i;
    @(posedge clk);
    i    = m_pos / P;
    e.fd = (m_pos == FRAME - 1);
    if ((m_pos % P) < B || m_dark(i)) begin
      e.an  = 4'hF;
      e.seg = 7'h7F;
    end else begin
      e.an  = 4'hF & ~(4'b0001 << i);
      e.seg = m_act[i];
    end
    if (m_pf) begin
      if (e.fd) begin
        for (int k = 0; k < 4; k++) m_act[k] = m_pend[k];
        m_pf = 1'b0;
      end
    end else if (in_valid) begin
      m_pend[0] = d0; m_pend[1] = d1; m_pend[2] = d2; m_pend[3] = d3;
      m_pf = 1'b1;
    end
    e.rdy = !m_pf;
    m_pos = (m_pos + 1) % FRAME;
    sb_q.push_back(e);

    @(negedge clk);
    got_e = sb_q.pop_front();
    check("an", an, got_e.an);
    check("seg", seg, got_e.seg);
    check("frame_done", frame_done, got_e.fd);
    check("in_ready", in_ready, got_e.rdy);
    check("an_onehot", ($countones(~an) <= 1), 1);
    if (an == 4'hF) begin
      gap_run++;
    end else begin
      if (gap_chk && last_lit != 4'hF && last_lit != an) check("blank_gap", gap_run, B);
      last_lit = an;
      gap_run  = 0;
    end
    if (an == 4'b0111 && seg == 7'b0000001) lit3_zero_cnt++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic offer(input logic [6:0] p3, input logic [6:0] p2,
                       input logic [6:0] p1, input logic [6:0] p0);
    d3 = p3; d2 = p2; d1 = p1; d0 = p0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    lit3_zero_cnt = 0;
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;

    run(10);
    offer(7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001);
    check("ready_drop", in_ready, 0);
    run(5);
    // Offered while the buffer is full: must be ignored.
    offer(7'b1111000, 7'b0001000, 7'b0110000, 7'b0100100);
    run(3 * FRAME);

    offer(7'b0011000, 7'b0011000, 7'b0011000, 7'b0011000);
    run(4);
    #2 rst_n = 1'b0;
    #1;
    check("async_an", an, 4'hF);
    check("async_seg", seg, 7'h7F);
    check("async_in_ready", in_ready, 1);
    check("async_frame_done", frame_done, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(2 * FRAME + 5);

`ifdef SEG_SCAN_LZB_EN
    gap_chk = 1'b0;
`endif
    lit3_zero_cnt = 0;
    offer(7'b0000001, 7'b0000001, 7'b1001111, 7'b0000001);
    run(3 * FRAME);
`ifdef SEG_SCAN_LZB_EN
    check("lzb_d3_dark", (lit3_zero_cnt == 0), 1);
`else
    check("lzb_d3_shown", (lit3_zero_cnt > 0), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
